cmp_led_sequencer: RTL and testbench

- Controller that sequences the 2-bit magnitude comparator / RGB LED datapath.
- Accepts operand pairs over a valid/ready handshake and drives the comparator's a1/a0/b1/b0 inputs.
- Samples the comparator's r/g/b outputs, holds the colour on the LEDs for a programmable time, then blanks for a programmable gap before accepting the next pair.
- Sits between a stimulus source (switch debouncer or test pattern generator) and the comparator instance on the board top level.

---
 rtl/cmp_seq_pkg.sv | 37 +++
 rtl/cmp_seq_timer.sv | 44 ++++
 rtl/cmp_led_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_cmp_led_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cmp_seq_pkg.sv
// Shared types and helpers for the comparator LED sequencer.
//   cmp_state_e   : sequencer FSM states
//   cmp_operand_t : 2-bit comparator operand
//   cmp_colour_t  : packed {r,g,b} colour as produced by the comparator
//   max_int       : elaboration-time helper for deriving the counter width
//   golden_colour : reference colour for a pair (r = a>=b, g = a<=b, b = a!=b)
package cmp_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        HOLD,
        GAP
    } cmp_state_e;

    typedef logic [1:0] cmp_operand_t;

    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } cmp_colour_t;

    function automatic int max_int(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    function automatic cmp_colour_t golden_colour(input cmp_operand_t a, input cmp_operand_t b);
        cmp_colour_t c;
        c.r = (a >= b);
        c.g = (a <= b);
        c.b = (a != b);
        return c;
    endfunction

endpackage

// File: rtl/cmp_seq_timer.sv
// Loadable down-counter shared by the HOLD and GAP phases.
// Ports:
//   clk, rst     : clock, synchronous active-high reset (count -> 0)
//   load_i       : load load_val_i this edge (has priority over en_i)
//   load_val_i   : value to load
//   en_i         : decrement this edge; saturates at zero, never wraps
//   count_o      : current count
//   zero_o       : count is zero
module cmp_seq_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;
    assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/cmp_led_sequencer.sv
// Sequencer for the 2-bit magnitude comparator / RGB LED datapath.
// Accepts an operand pair (valid/ready), drives it onto the comparator,
// waits one settle cycle, samples the comparator colour onto the LEDs for
// HOLD_CYCLES, blanks for GAP_CYCLES, then pulses done and returns to IDLE.
//
// Handshake: a pair transfers on a rising clk edge where in_valid and
// in_ready are both high. in_ready is high only in IDLE (and never during
// rst); in_valid outside IDLE is ignored, not queued.
//
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   in_valid, in_ready      : operand handshake
//   op_a, op_b              : operand pair
//   a1, a0, b1, b0          : registered operand bits to the comparator
//   cmp_r, cmp_g, cmp_b     : comparator outputs
//   led_r, led_g, led_b     : registered LED drive
//   busy                    : not in IDLE
//   done                    : one-cycle pulse on the last display/blank cycle
//   err                     : sticky comparator self-check failure
//
// Build option: define CMP_SEQ_CHECK_EN to compare the comparator against a
// golden model in SAMPLE; otherwise err is tied low.
module cmp_led_sequencer
    import cmp_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 8,
    parameter int GAP_CYCLES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] op_a,
    input  logic [1:0] op_b,
    output logic       a1,
    output logic       a0,
    output logic       b1,
    output logic       b0,
    input  logic       cmp_r,
    input  logic       cmp_g,
    input  logic       cmp_b,
    output logic       led_r,
    output logic       led_g,
    output logic       led_b,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, GAP_CYCLES) + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam bit HAS_GAP  = (GAP_CYCLES > 0);
    localparam bit GAP_ONE  = (GAP_CYCLES == 1);
    localparam bit HOLD_ONE = (HOLD_CYCLES == 1);

    cmp_state_e   state_q;
    cmp_operand_t a_q;
    cmp_operand_t b_q;
    cmp_colour_t  led_q;
    logic         done_q;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_en;
    logic [CNT_W-1:0] tmr_cnt;
    logic             tmr_zero;

    cmp_colour_t cmp_col;
    assign cmp_col = '{r: cmp_r, g: cmp_g, b: cmp_b};

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = HOLD_LOAD;
        tmr_en   = 1'b0;
        case (state_q)
            SAMPLE: tmr_load = 1'b1;
            HOLD: begin
                if (tmr_zero && HAS_GAP) begin
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LOAD;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            GAP:     tmr_en = 1'b1;
            default: ;
        endcase
    end

    cmp_seq_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .en_i       (tmr_en),
        .count_o    (tmr_cnt),
        .zero_o     (tmr_zero)
    );

    // done is registered, so it is set one edge early: whenever the next
    // cycle is the final HOLD (no gap) or final GAP cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            led_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= op_a;
                        b_q     <= op_b;
                        state_q <= DRIVE;
                    end
                end
                DRIVE: state_q <= SAMPLE;
                SAMPLE: begin
                    led_q   <= cmp_col;
                    state_q <= HOLD;
                    if (HOLD_ONE && !HAS_GAP) begin
                        done_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (tmr_zero) begin
                        led_q <= '0;
                        if (HAS_GAP) begin
                            state_q <= GAP;
                            if (GAP_ONE) begin
                                done_q <= 1'b1;
                            end
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (!HAS_GAP && (tmr_cnt == CNT_ONE)) begin
                        done_q <= 1'b1;
                    end
                end
                GAP: begin
                    if (tmr_zero) begin
                        state_q <= IDLE;
                    end else if (tmr_cnt == CNT_ONE) begin
                        done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef CMP_SEQ_CHECK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((state_q == SAMPLE) && (golden_colour(a_q, b_q) != cmp_col)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign in_ready = (state_q == IDLE) && !rst;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign {a1, a0} = a_q;
    assign {b1, b0} = b_q;
    assign led_r    = led_q.r;
    assign led_g    = led_q.g;
    assign led_b    = led_q.b;

endmodule

// File: tb/tb_cmp_led_sequencer.sv
module tb_cmp_led_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- DUT 0: default HOLD=8, GAP=2 ----------------
    logic       v0 = 1'b0;
    logic       rdy0;
    logic [1:0] opa0 = '0;
    logic [1:0] opb0 = '0;
    logic       a1_0, a0_0, b1_0, b0_0;
    logic       cr0, cg0, cb0;
    logic       lr0, lg0, lb0;
    logic       busy0, done0, err0;
    logic       bad_b = 1'b0;
    logic       exp_err = 1'b0;

    // Behavioural comparator; bad_b forces the b output low.
    always_comb begin
        cr0 = ({a1_0, a0_0} >= {b1_0, b0_0});
        cg0 = ({a1_0, a0_0} <= {b1_0, b0_0});
        cb0 = ({a1_0, a0_0} != {b1_0, b0_0}) && !bad_b;
    end

    cmp_led_sequencer u_dut0 (
        .clk(clk), .rst(rst), .in_valid(v0), .in_ready(rdy0),
        .op_a(opa0), .op_b(opb0),
        .a1(a1_0), .a0(a0_0), .b1(b1_0), .b0(b0_0),
        .cmp_r(cr0), .cmp_g(cg0), .cmp_b(cb0),
        .led_r(lr0), .led_g(lg0), .led_b(lb0),
        .busy(busy0), .done(done0), .err(err0)
    );

    // ---------------- DUT 1: HOLD=1, GAP=0 ----------------
    logic       v1 = 1'b0;
    logic       rdy1;
    logic [1:0] opa1 = '0;
    logic [1:0] opb1 = '0;
    logic       a1_1, a0_1, b1_1, b0_1;
    logic       cr1, cg1, cb1;
    logic       lr1, lg1, lb1;
    logic       busy1, done1, err1;

    always_comb begin
        cr1 = ({a1_1, a0_1} >= {b1_1, b0_1});
        cg1 = ({a1_1, a0_1} <= {b1_1, b0_1});
        cb1 = ({a1_1, a0_1} != {b1_1, b0_1});
    end

    cmp_led_sequencer #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1),
        .op_a(opa1), .op_b(opb1),
        .a1(a1_1), .a0(a0_1), .b1(b1_1), .b0(b0_1),
        .cmp_r(cr1), .cmp_g(cg1), .cmp_b(cb1),
        .led_r(lr1), .led_g(lg1), .led_b(lb1),
        .busy(busy1), .done(done1), .err(err1)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on DUT 0 starting in IDLE. With nxt_en, a new pair
    // is presented from the first HOLD cycle on and left valid at return.
    task automatic run_pair(input logic [1:0] pa, input logic [1:0] pb, input logic [2:0] exp_led,
                            input bit nxt_en, input logic [1:0] na, input logic [1:0] nb);
        check("ready_idle", {7'd0, rdy0}, 8'd1);
        v0 = 1'b1; opa0 = pa; opb0 = pb;
        step();                                   // T+1 DRIVE
        v0 = 1'b0;
        check("ops_drive", {4'd0, a1_0, a0_0, b1_0, b0_0}, {4'd0, pa, pb});
        check("busy_drive", {7'd0, busy0}, 8'd1);
        check("ready_drive", {7'd0, rdy0}, 8'd0);
        step();                                   // T+2 SAMPLE
        check("led_sample", {5'd0, lr0, lg0, lb0}, 8'd0);
        check("busy_sample", {7'd0, busy0}, 8'd1);
        for (int i = 0; i < 8; i++) begin
            step();                               // T+3 .. T+10 HOLD
            check("led_hold", {5'd0, lr0, lg0, lb0}, {5'd0, exp_led});
            check("busy_hold", {7'd0, busy0}, 8'd1);
            check("done_hold", {7'd0, done0}, 8'd0);
            check("ready_hold", {7'd0, rdy0}, 8'd0);
            check("err_hold", {7'd0, err0}, {7'd0, exp_err});
            check("ops_hold", {4'd0, a1_0, a0_0, b1_0, b0_0}, {4'd0, pa, pb});
            if (nxt_en && i == 0) begin
                v0 = 1'b1; opa0 = na; opb0 = nb;
            end
        end
        for (int i = 0; i < 2; i++) begin
            step();                               // GAP
            check("led_gap", {5'd0, lr0, lg0, lb0}, 8'd0);
            check("done_gap", {7'd0, done0}, (i == 1) ? 8'd1 : 8'd0);
            check("busy_gap", {7'd0, busy0}, 8'd1);
            check("ops_gap", {4'd0, a1_0, a0_0, b1_0, b0_0}, {4'd0, pa, pb});
        end
        step();                                   // back in IDLE
        check("done_idle", {7'd0, done0}, 8'd0);
        check("busy_idle", {7'd0, busy0}, 8'd0);
        check("ready_after", {7'd0, rdy0}, 8'd1);
        check("ops_idle", {4'd0, a1_0, a0_0, b1_0, b0_0}, {4'd0, pa, pb});
    endtask

    initial begin
        // ---- reset ----
        step();
        step();
        check("rst_ready0", {7'd0, rdy0}, 8'd0);
        check("rst_ready1", {7'd0, rdy1}, 8'd0);
        check("rst_outs0", {a1_0, a0_0, b1_0, b0_0, lr0, lg0, lb0, busy0}, 8'd0);
        check("rst_flags0", {6'd0, done0, err0}, 8'd0);
        check("rst_outs1", {a1_1, a0_1, b1_1, b0_1, lr1, lg1, lb1, busy1}, 8'd0);
        check("rst_flags1", {6'd0, done1, err1}, 8'd0);
        rst = 1'b0;
        #1;
        check("ready_post_rst", {7'd0, rdy0}, 8'd1);
        step();

        // ---- greater, equal, less (+backpressure), then the held pair ----
        run_pair(2'd2, 2'd1, 3'b101, 1'b0, 2'd0, 2'd0);
        run_pair(2'd1, 2'd1, 3'b110, 1'b0, 2'd0, 2'd0);
        run_pair(2'd0, 2'd3, 3'b011, 1'b1, 2'd3, 2'd0);
        run_pair(2'd3, 2'd0, 3'b101, 1'b0, 2'd0, 2'd0);

`ifdef CMP_SEQ_CHECK_EN
        // ---- faulty comparator sets sticky err from T+3 ----
        bad_b   = 1'b1;
        exp_err = 1'b1;
        run_pair(2'd2, 2'd1, 3'b100, 1'b0, 2'd0, 2'd0);
        bad_b = 1'b0;
        run_pair(2'd1, 2'd2, 3'b011, 1'b0, 2'd0, 2'd0);
`endif

        // ---- reset in HOLD cycle 4 ----
        v0 = 1'b1; opa0 = 2'd2; opb0 = 2'd1;
        step();
        v0 = 1'b0;
        step();
        for (int i = 0; i < 4; i++) step();
        check("led_pre_rst", {5'd0, lr0, lg0, lb0}, 8'b101);
        rst = 1'b1;
        step();
        exp_err = 1'b0;
        check("mid_rst_outs", {a1_0, a0_0, b1_0, b0_0, lr0, lg0, lb0, busy0}, 8'd0);
        check("mid_rst_flags", {6'd0, done0, err0}, 8'd0);
        check("mid_rst_ready", {7'd0, rdy0}, 8'd0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", {7'd0, rdy0}, 8'd1);
        for (int i = 0; i < 12; i++) begin
            step();
            check("no_done_after_rst", {6'd0, done0, busy0}, 8'd0);
        end

        // ---- HOLD=1, GAP=0 instance ----
        v1 = 1'b1; opa1 = 2'd0; opb1 = 2'd0;
        step();                                   // T+1
        v1 = 1'b0;
        check("d1_ops", {4'd0, a1_1, a0_1, b1_1, b0_1}, 8'd0);
        check("d1_busy", {7'd0, busy1}, 8'd1);
        step();                                   // T+2
        check("d1_led_sample", {5'd0, lr1, lg1, lb1}, 8'd0);
        check("d1_done_sample", {7'd0, done1}, 8'd0);
        step();                                   // T+3
        check("d1_led", {5'd0, lr1, lg1, lb1}, 8'b110);
        check("d1_done", {7'd0, done1}, 8'd1);
        check("d1_ready_hold", {7'd0, rdy1}, 8'd0);
        step();                                   // T+4
        check("d1_led_off", {5'd0, lr1, lg1, lb1}, 8'd0);
        check("d1_done_off", {7'd0, done1}, 8'd0);
        check("d1_ready", {7'd0, rdy1}, 8'd1);
        v1 = 1'b1; opa1 = 2'd2; opb1 = 2'd1;
        step();
        v1 = 1'b0;
        check("d1_ops2", {4'd0, a1_1, a0_1, b1_1, b0_1}, 8'b1001);
        check("d1_busy2", {7'd0, busy1}, 8'd1);
        step();
        step();
        check("d1_led2", {5'd0, lr1, lg1, lb1}, 8'b101);
        check("d1_done2", {7'd0, done1}, 8'd1);
        step();
        check("d1_idle2", {6'd0, busy1, rdy1}, 8'b01);
        check("d1_err", {7'd0, err1}, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
